// File: rtl/sram_like_responder_if.sv
// SRAM-like req/addr_ok/data_ok bus between an initiator (master) and a responder (slave).
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_responder.sv
// In-order SRAM-like responder backed by a word memory; responses come a programmable latency after accept.
// Optional macro RAND_BACKPRESSURE_EN adds LFSR-driven accept gating and extra response delay.
module sram_like_responder #(
    parameter int    DEPTH     = 4,
    parameter int    LATENCY   = 2,
    parameter int    MEM_WORDS = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_responder_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int AGE_W = $clog2(LATENCY + 4) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + AGE_W'(1);
    endfunction

    logic [31:0]      r_mem     [MEM_WORDS];
    logic             r_q_wr    [DEPTH];
    logic [IDX_W-1:0] r_q_idx   [DEPTH];
    logic [31:0]      r_q_wdata [DEPTH];
    logic [3:0]       r_q_wstrb [DEPTH];
    logic [AGE_W-1:0] r_q_age   [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_data_ok;
    logic [31:0]      r_rdata;

    logic             w_bp_open;
    logic [AGE_W-1:0] w_thresh;
    logic             w_accept_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_resp_nxt;
    logic [PTR_W-1:0] w_head_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [AGE_W-1:0] w_age_nxt [DEPTH];
    logic             w_head_wr;
    logic [IDX_W-1:0] w_head_idx;
    logic [31:0]      w_head_wdata;
    logic [3:0]       w_head_wstrb;
    logic             w_unused;

`ifdef RAND_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_bp_open = r_lfsr[0];
    assign w_thresh  = AGE_W'(LATENCY - 1) + AGE_W'(r_lfsr[2:1]);
`else
    assign w_bp_open = 1'b1;
    assign w_thresh  = AGE_W'(LATENCY - 1);
`endif

    // Accept depends only on occupancy (and reset), never on req.
    assign w_accept_ok  = !reset && (r_count < CNT_W'(DEPTH)) && w_bp_open;
    assign w_push       = bus.req && w_accept_ok;
    assign w_pop        = r_data_ok;
    assign w_head_nxt   = r_rptr + PTR_W'(w_pop);
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Queue empties this edge while a new request lands: the new request is the next head.
    assign w_bypass     = w_push && (r_count == CNT_W'(w_pop));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_age_nxt[i] = (w_push && (r_wptr == PTR_W'(i))) ? '0 : sat_inc(r_q_age[i]);
        end
    end

    always_comb begin
        w_head_wr    = r_q_wr[w_head_nxt];
        w_head_idx   = r_q_idx[w_head_nxt];
        w_head_wdata = r_q_wdata[w_head_nxt];
        w_head_wstrb = r_q_wstrb[w_head_nxt];
        if (w_bypass) begin
            w_head_wr    = bus.wr;
            w_head_idx   = bus.addr[IDX_W+1:2];
            w_head_wdata = bus.wdata;
            w_head_wstrb = bus.wstrb;
        end
    end

    assign w_resp_nxt = (w_count_nxt != '0) && (w_age_nxt[w_head_nxt] >= w_thresh);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rptr    <= w_head_nxt;
            r_count   <= w_count_nxt;
            r_data_ok <= w_resp_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_resp_nxt) begin
                r_rdata <= w_head_wr ? 32'h0 : r_mem[w_head_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_q_age[i] <= w_age_nxt[i];
        end
        if (w_push) begin
            r_q_wr[r_wptr]    <= bus.wr;
            r_q_idx[r_wptr]   <= bus.addr[IDX_W+1:2];
            r_q_wdata[r_wptr] <= bus.wdata;
            r_q_wstrb[r_wptr] <= bus.wstrb;
        end
    end

    // Memory is touched only when a response is issued, so effects follow acceptance order.
    always_ff @(posedge clk) begin
        if (!reset && w_resp_nxt && w_head_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_head_wstrb[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.addr_ok = w_accept_ok;
    assign bus.data_ok = r_data_ok;
    assign bus.rdata   = r_rdata;
    assign w_unused    = ^{bus.size, bus.addr[31:IDX_W+2], bus.addr[1:0]};
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_sram_like_responder;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 1024;
    localparam int M_LAT     = 2;
    localparam int SEL_M = 0, SEL_F = 1, SEL_S = 2;

    logic clk = 1'b0;
    logic rst_m, rst_8, rst_1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_responder_if m_if ();
    sram_like_responder_if f_if ();
    sram_like_responder_if s_if ();

    sram_like_responder #(.DEPTH(DEPTH), .LATENCY(2), .MEM_WORDS(MEM_WORDS), .INIT_FILE(""))
        u_dut_l2 (.clk(clk), .reset(rst_m), .bus(m_if.slave));
    sram_like_responder #(.DEPTH(DEPTH), .LATENCY(8), .MEM_WORDS(MEM_WORDS), .INIT_FILE(""))
        u_dut_l8 (.clk(clk), .reset(rst_8), .bus(f_if.slave));
    sram_like_responder #(.DEPTH(DEPTH), .LATENCY(1), .MEM_WORDS(MEM_WORDS), .INIT_FILE(""))
        u_dut_l1 (.clk(clk), .reset(rst_1), .bus(s_if.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rq, input logic w, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        case (sel)
            SEL_M: begin m_if.req = rq; m_if.wr = w; m_if.size = sz; m_if.wstrb = st; m_if.addr = a; m_if.wdata = d; end
            SEL_F: begin f_if.req = rq; f_if.wr = w; f_if.size = sz; f_if.wstrb = st; f_if.addr = a; f_if.wdata = d; end
            default: begin s_if.req = rq; s_if.wr = w; s_if.size = sz; s_if.wstrb = st; s_if.addr = a; s_if.wdata = d; end
        endcase
    endtask

    function automatic logic get_addr_ok(input int sel);
        case (sel)
            SEL_M: return m_if.addr_ok;
            SEL_F: return f_if.addr_ok;
            default: return s_if.addr_ok;
        endcase
    endfunction

    function automatic logic get_data_ok(input int sel);
        case (sel)
            SEL_M: return m_if.data_ok;
            SEL_F: return f_if.data_ok;
            default: return s_if.data_ok;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        case (sel)
            SEL_M: return m_if.rdata;
            SEL_F: return f_if.rdata;
            default: return s_if.rdata;
        endcase
    endfunction

    // One isolated transaction: returns accept flag, cycles from request to data_ok, and rdata.
    task automatic op(input int sel, input logic w, input logic [1:0] sz, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic acc, output int lat, output logic [31:0] rd);
        int t0;
        @(posedge clk); #1;
        drive(sel, 1'b1, w, sz, st, a, d);
        @(negedge clk);
        acc = get_addr_ok(sel);
        t0  = cyc;
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        lat = -1;
        rd  = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_data_ok(sel)) begin
                lat = cyc - t0;
                rd  = get_rdata(sel);
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input int sel, input int exp_lat, input logic w,
                            input logic [3:0] st, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd);
        logic acc; int lat; logic [31:0] rd;
        op(sel, w, 2'd2, st, a, d, acc, lat, rd);
        check({name, "_addr_ok"}, acc, 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_rdata"}, rd, exp_rd);
    endtask

    // Reference model for the LATENCY=2 instance: pending queue with due cycles, memory applied at response.
    typedef struct {
        logic        wr;
        int unsigned idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          due;
    } pend_t;

    pend_t       mq[$];
    pend_t       me;
    logic [31:0] mdl_mem   [MEM_WORDS];
    bit          mdl_known [MEM_WORDS];
    int          last_due = 0;

    always @(negedge clk) begin
        if (rst_m) begin
            check("m_addr_ok_in_reset", m_if.addr_ok, 0);
            mq.delete();
            last_due = 0;
        end else begin
            check("m_addr_ok", m_if.addr_ok, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
            if (mq.size() != 0 && mq[0].due < cyc) begin
                check("m_missed_response", cyc, mq[0].due);
                void'(mq.pop_front());
            end
            if (m_if.data_ok) begin
                if (mq.size() == 0) begin
                    check("m_spurious_data_ok", 1, 0);
                end else begin
                    me = mq.pop_front();
                    check("m_response_cycle", cyc, me.due);
                    if (me.wr) begin
                        check("m_write_rdata", m_if.rdata, 0);
                        for (int b = 0; b < 4; b++)
                            if (me.wstrb[b]) mdl_mem[me.idx][8*b +: 8] = me.wdata[8*b +: 8];
                        if (me.wstrb == 4'hF) mdl_known[me.idx] = 1'b1;
                    end else if (mdl_known[me.idx]) begin
                        check("m_read_rdata", m_if.rdata, mdl_mem[me.idx]);
                    end
                end
            end
            if (m_if.req && m_if.addr_ok) begin
                me.wr    = m_if.wr;
                me.idx   = (m_if.addr >> 2) % MEM_WORDS;
                me.wdata = m_if.wdata;
                me.wstrb = m_if.wstrb;
                me.due   = (cyc + M_LAT > last_due + 1) ? cyc + M_LAT : last_due + 1;
                last_due = me.due;
                mq.push_back(me);
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0111);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t        vt[13];
        logic        acc_last;
        logic        acc;
        int          lat;
        logic [31:0] rd;
        int          acc_c[6];
        int          rsp_c[6];
        int          na, nr, nacc, nrsp;

        vt[0]  = '{1'b1, 2'd2, 4'hF,    32'h0000_0014, 32'h1234_5678, 32'h0};
        vt[1]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0014, 32'h0,         32'h1234_5678};
        vt[2]  = '{1'b1, 2'd2, 4'hF,    32'h0000_000C, 32'hFFFF_FFFF, 32'h0};
        vt[3]  = '{1'b1, 2'd0, 4'b0101, 32'h0000_000C, 32'hAABB_CCDD, 32'h0};
        vt[4]  = '{1'b0, 2'd2, 4'h0,    32'h0000_000C, 32'h0,         32'hFFBB_FFDD};
        vt[5]  = '{1'b1, 2'd2, 4'hF,    32'h0000_1000, 32'hDEAD_BEEF, 32'h0};
        vt[6]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0000, 32'h0,         32'hDEAD_BEEF};
        vt[7]  = '{1'b1, 2'd2, 4'hF,    32'h0000_0020, 32'h55AA_55AA, 32'h0};
        vt[8]  = '{1'b1, 2'd2, 4'h0,    32'h0000_0020, 32'h1111_1111, 32'h0};
        vt[9]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0023, 32'h0,         32'h55AA_55AA};
        vt[10] = '{1'b1, 2'd1, 4'b1100, 32'h0000_0022, 32'hCAFE_0000, 32'h0};
        vt[11] = '{1'b0, 2'd2, 4'h0,    32'h0000_0020, 32'h0,         32'hCAFE_55AA};
        vt[12] = '{1'b0, 2'd2, 4'h0,    32'hFFFF_F014, 32'h0,         32'h1234_5678};

        rst_m = 1'b1; rst_8 = 1'b1; rst_1 = 1'b1;
        drive(SEL_M, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        drive(SEL_F, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        drive(SEL_S, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr_ok_l8", f_if.addr_ok, 0);
        check("rst_addr_ok_l1", s_if.addr_ok, 0);
        check("rst_data_ok_l2", m_if.data_ok, 0);
        check("rst_rdata_l8", f_if.rdata, 0);
        @(posedge clk); #1;
        rst_m = 1'b0; rst_8 = 1'b0; rst_1 = 1'b0;
        @(negedge clk);
        check("post_rst_addr_ok_l8", f_if.addr_ok, 1);
        check("post_rst_data_ok_l1", s_if.data_ok, 0);

        // Directed single transactions, LATENCY=2.
        for (int i = 0; i < 13; i++) begin
            op(SEL_M, vt[i].wr, vt[i].size, vt[i].wstrb, vt[i].addr, vt[i].wdata, acc, lat, rd);
            check($sformatf("vec%0d_addr_ok", i), acc, 1);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        end

        // Randomized traffic on the LATENCY=2 instance, checked by the model.
        acc_last = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!m_if.req || acc_last) begin
                if (c < 16) begin
                    drive(SEL_M, 1'b1, 1'b1, 2'd2, 4'hF, 32'(c) << 2, $urandom);
                end else begin
                    drive(SEL_M, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                          $urandom);
                end
            end
            @(negedge clk);
            acc_last = m_if.req && m_if.addr_ok;
        end
        @(posedge clk); #1;
        drive(SEL_M, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        repeat (12) @(negedge clk);
        check("m_queue_drained", mq.size(), 0);

        // LATENCY=8: preload, then fill to full with the request held high.
        for (int k = 0; k < 6; k++)
            check_op($sformatf("l8_preload%0d", k), SEL_F, 8, 1'b1, 4'hF,
                     32'h100 + 32'(4 * k), 32'hF00D_0000 + 32'(k), 32'h0);
        for (int k = 0; k < 6; k++) begin acc_c[k] = -100; rsp_c[k] = -100; end
        na = 0; nr = 0;
        @(posedge clk); #1;
        drive(SEL_F, 1'b1, 1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
        for (int t = 0; t < 80 && nr < 6; t++) begin
            @(negedge clk);
            if (f_if.data_ok) begin
                if (nr < 6) begin
                    rsp_c[nr] = cyc;
                    check($sformatf("fill_rsp%0d_rdata", nr), f_if.rdata, 32'hF00D_0000 + 32'(nr));
                end
                nr++;
            end
            if (f_if.req && f_if.addr_ok) begin
                if (na < 6) acc_c[na] = cyc;
                na++;
            end
            @(posedge clk); #1;
            if (na < 6) drive(SEL_F, 1'b1, 1'b0, 2'd2, 4'h0, 32'h100 + 32'(4 * na), 32'h0);
            else        drive(SEL_F, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        end
        drive(SEL_F, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        check("fill_accepts", na, 6);
        check("fill_responses", nr, 6);
        check("fill_first_four_back_to_back", acc_c[3] - acc_c[0], 3);
        check("fill_first_rsp_latency", rsp_c[0] - acc_c[0], 8);
        check("fill_rsp_burst", rsp_c[3] - rsp_c[0], 3);
        check("fill_fifth_accept", acc_c[4], rsp_c[0] + 1);
        check("fill_sixth_accept", acc_c[5], rsp_c[1] + 1);

        // LATENCY=8: reset with three requests in flight (third is a write that must be lost).
        nacc = 0; nrsp = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(SEL_F, 1'b1, i == 2, 2'd2, 4'hF, 32'h100 + 32'(4 * i), 32'hBAD0_BAD0);
            @(negedge clk);
            if (f_if.addr_ok) nacc++;
        end
        @(posedge clk); #1;
        drive(SEL_F, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
        rst_8 = 1'b1;
        @(negedge clk);
        check("midrst_addr_ok_in_reset", f_if.addr_ok, 0);
        @(posedge clk); #1;
        rst_8 = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (f_if.data_ok) nrsp++;
        end
        check("midrst_accepts", nacc, 3);
        check("midrst_no_data_ok", nrsp, 0);
        check_op("midrst_fresh_read", SEL_F, 8, 1'b0, 4'h0, 32'h104, 32'h0, 32'hF00D_0001);
        check_op("midrst_write_lost", SEL_F, 8, 1'b0, 4'h0, 32'h108, 32'h0, 32'hF00D_0002);

        // LATENCY=1 streaming: 16 writes then 16 reads with req held high.
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk); #1;
            drive(SEL_S, 1'b1, ph == 0, 2'd2, 4'hF, 32'h0, pat(0));
            for (int i = 0; i < 17; i++) begin
                @(negedge clk);
                if (i < 16) check($sformatf("stream%0d_accept%0d", ph, i), s_if.addr_ok, 1);
                if (i == 0) begin
                    check($sformatf("stream%0d_no_early_rsp", ph), s_if.data_ok, 0);
                end else begin
                    check($sformatf("stream%0d_data_ok%0d", ph, i - 1), s_if.data_ok, 1);
                    check($sformatf("stream%0d_rdata%0d", ph, i - 1), s_if.rdata,
                          (ph == 0) ? 32'h0 : pat(i - 1));
                end
                @(posedge clk); #1;
                if (i < 15) drive(SEL_S, 1'b1, ph == 0, 2'd2, 4'hF, 32'(4 * (i + 1)), pat(i + 1));
                else        drive(SEL_S, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
            end
            @(negedge clk);
            check($sformatf("stream%0d_end_quiet", ph), s_if.data_ok, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
